// File: rtl/vblank_update_sched.sv
// vblank_update_sched: registered VGA pixel coordinates plus a per-frame
// scheduler that grants game-state update clients one at a time during vertical blank.
module vblank_update_sched #(
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VBP     = 31,
    parameter int VFP     = 511,
    parameter int NCLIENT = 3
) (
    input  logic               dclk,
    input  logic               clr,
    input  logic [9:0]         hc,
    input  logic [9:0]         vc,
    input  logic [NCLIENT-1:0] upd_done,
    output logic [NCLIENT-1:0] upd_go,
    output logic               video_on,
    output logic [9:0]         px,
    output logic [8:0]         py,
    output logic               frame_tick,
    output logic [15:0]        frame_cnt,
    output logic               overrun,
    output logic [7:0]         ovr_cnt
);

    localparam int IW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

    localparam logic [9:0]         HPIX_V   = 10'(HPIXELS);
    localparam logic [9:0]         VLIN_V   = 10'(VLINES);
    localparam logic [9:0]         HBP_V    = 10'(HBP);
    localparam logic [9:0]         HFP_V    = 10'(HFP);
    localparam logic [9:0]         VBP_V    = 10'(VBP);
    localparam logic [9:0]         VFP_V    = 10'(VFP);
    localparam logic [IW-1:0]      LAST_IDX = IW'(NCLIENT - 1);
    localparam logic [NCLIENT-1:0] FIRST_GO = NCLIENT'(1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NCLIENT-1:0]  go_q, go_d;
    logic                frame_tick_q, frame_tick_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          ovr_cnt_q, ovr_cnt_d;
    logic                video_on_q, video_on_d;
    logic [9:0]          px_q, px_d;
    logic [8:0]          py_q, py_d;

    logic start_ev;
    logic deadline_ev;
    logic ack;
    logic last;

    // Pixel path: out-of-range counters never count as active video.
    always_comb begin
        video_on_d = (hc < HPIX_V) && (vc < VLIN_V) &&
                     (hc >= HBP_V) && (hc < HFP_V) &&
                     (vc >= VBP_V) && (vc < VFP_V);
        px_d = '0;
        py_d = '0;
        if (video_on_d) begin
            px_d = hc - HBP_V;
            py_d = 9'(vc - VBP_V);
        end
    end

    assign start_ev    = (hc == 10'd0) && (vc == VFP_V);
    assign deadline_ev = (hc == 10'd0) && (vc == VBP_V);
    assign ack         = go_q[idx_q] & upd_done[idx_q];
    assign last        = (idx_q == LAST_IDX);

    // A blank start in any state opens a new frame; in GRANT it first
    // closes the old one exactly like a deadline would.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        go_d         = '0;
        frame_tick_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        overrun_d    = 1'b0;
        ovr_cnt_d    = ovr_cnt_q;

        case (state_q)
            GRANT: begin
                if (deadline_ev || start_ev) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    if (!(ack && last)) begin
                        overrun_d = 1'b1;
                        ovr_cnt_d = (ovr_cnt_q == 8'hFF) ? ovr_cnt_q : ovr_cnt_q + 8'd1;
                    end
                end else if (ack) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    go_d = FIRST_GO << idx_q;
                end
            end
            DONE: begin
                if (deadline_ev) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase

        if (start_ev) begin
            state_d      = GRANT;
            idx_d        = '0;
            go_d         = FIRST_GO;
            frame_tick_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            go_q         <= '0;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
            overrun_q    <= 1'b0;
            ovr_cnt_q    <= '0;
            video_on_q   <= 1'b0;
            px_q         <= '0;
            py_q         <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            go_q         <= go_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
            ovr_cnt_q    <= ovr_cnt_d;
            video_on_q   <= video_on_d;
            px_q         <= px_d;
            py_q         <= py_d;
        end
    end

    assign upd_go     = go_q;
    assign video_on   = video_on_q;
    assign px         = px_q;
    assign py         = py_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;
    assign ovr_cnt    = ovr_cnt_q;

endmodule

// File: tb/tb_vblank_update_sched.sv
// tb_vblank_update_sched: random hc/vc and client stimulus checked every cycle
// against a frame-level behavioural model, plus literal expectations.
module tb_vblank_update_sched;

    localparam int N   = 3;
    localparam int VBP = 31;
    localparam int VFP = 511;

    logic          dclk = 1'b0;
    logic          clr;
    logic [9:0]    hc;
    logic [9:0]    vc;
    logic [N-1:0]  upd_done;
    logic [N-1:0]  upd_go;
    logic          video_on;
    logic [9:0]    px;
    logic [8:0]    py;
    logic          frame_tick;
    logic [15:0]   frame_cnt;
    logic          overrun;
    logic [7:0]    ovr_cnt;

    vblank_update_sched #(.NCLIENT(N)) dut (
        .dclk       (dclk),
        .clr        (clr),
        .hc         (hc),
        .vc         (vc),
        .upd_done   (upd_done),
        .upd_go     (upd_go),
        .video_on   (video_on),
        .px         (px),
        .py         (py),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt),
        .overrun    (overrun),
        .ovr_cnt    (ovr_cnt)
    );

    always #5 dclk = ~dclk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit stray_en = 1'b0;

    // Frame-level model: which client is owed a grant, and whether its go is up.
    bit m_busy, m_go_on, m_tick, m_over, m_von;
    int m_client, m_frames, m_ovr, m_px, m_py;
    int delay [N];
    int age;

    function automatic void model_reset();
        m_busy = 0; m_go_on = 0; m_tick = 0; m_over = 0; m_von = 0;
        m_client = 0; m_frames = 0; m_ovr = 0; m_px = 0; m_py = 0; age = 0;
    endfunction

    function automatic int exp_go();
        return (m_busy && m_go_on) ? (1 << m_client) : 0;
    endfunction

    function automatic void model_step();
        bit start, dl, done;
        start = (hc == 10'd0) && (vc == 10'(VFP));
        dl    = (hc == 10'd0) && (vc == 10'(VBP));
        done  = m_busy && m_go_on && upd_done[m_client];
        m_tick = 0;
        m_over = 0;
        m_von = (hc >= 144) && (hc < 784) && (vc >= 31) && (vc < 511);
        m_px  = m_von ? int'(hc) - 144 : 0;
        m_py  = m_von ? int'(vc) - 31 : 0;
        if (m_busy) begin
            if (done) begin
                m_go_on = 0;
                if (m_client == N - 1) m_busy = 0;
                else m_client++;
            end else begin
                m_go_on = 1;
            end
        end
        if ((dl || start) && m_busy) begin
            m_over = 1;
            if (m_ovr < 255) m_ovr++;
            m_busy = 0;
            m_go_on = 0;
        end
        if (start) begin
            m_tick = 1;
            m_frames = (m_frames + 1) % 65536;
            m_busy = 1;
            m_client = 0;
            m_go_on = 1;
        end
    endfunction

    function automatic void check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Clients ack once their go has been up for more than delay[i] cycles; -1 never acks.
    function automatic void drive_clients();
        logic [N-1:0] d;
        d = stray_en ? N'($urandom) : '0;
        if (exp_go() != 0) begin
            age++;
            d[m_client] = (delay[m_client] >= 0) && (age > delay[m_client]);
        end else begin
            age = 0;
        end
        upd_done = d;
    endfunction

    task automatic apply_stimulus(input logic [9:0] h, input logic [9:0] v);
        hc = h;
        vc = v;
        drive_clients();
        @(posedge dclk);
        if (clr) model_reset();
        else model_step();
        #1;
    endtask

    task automatic rand_cycle();
        logic [9:0] h, v;
        h = 10'($urandom_range(0, 799));
        v = 10'($urandom_range(0, 520));
        if (h == 10'd0 && (v == 10'(VFP) || v == 10'(VBP))) h = 10'd1;
        apply_stimulus(h, v);
    endtask

    task automatic run_frame(input int d0, input int d1, input int d2,
                             input int blank_len, input bit with_deadline);
        delay[0] = d0;
        delay[1] = d1;
        delay[2] = d2;
        apply_stimulus(10'd0, 10'(VFP));
        repeat (blank_len) rand_cycle();
        if (with_deadline) apply_stimulus(10'd0, 10'(VBP));
    endtask

    always @(negedge dclk) begin
        if (cmp_en) begin
            check_output("upd_go", int'(upd_go), exp_go());
            check_output("frame_tick", int'(frame_tick), int'(m_tick));
            check_output("frame_cnt", int'(frame_cnt), m_frames);
            check_output("overrun", int'(overrun), int'(m_over));
            check_output("ovr_cnt", int'(ovr_cnt), m_ovr);
            check_output("video_on", int'(video_on), int'(m_von));
            check_output("px", int'(px), m_px);
            check_output("py", int'(py), m_py);
        end
    end

    initial begin
        clr = 1'b1;
        hc = '0;
        vc = '0;
        upd_done = '0;
        model_reset();
        for (int i = 0; i < N; i++) delay[i] = 10;
        repeat (3) @(posedge dclk);
        #1;
        cmp_en = 1'b1;
        clr = 1'b0;

        // Reset mid-grant clears everything at once; restart waits for a blank start.
        apply_stimulus(10'd0, 10'(VFP));
        repeat (5) rand_cycle();
        clr = 1'b1;
        model_reset();
        #1;
        check_output("rst_go", int'(upd_go), 0);
        check_output("rst_cnt", int'(frame_cnt), 0);
        check_output("rst_video", int'(video_on) + int'(px) + int'(py), 0);
        repeat (2) rand_cycle();
        clr = 1'b0;
        apply_stimulus(10'd7, 10'd100);
        repeat (30) rand_cycle();
        run_frame(10, 10, 10, 50, 1);
        check_output("reset_frame_cnt", int'(frame_cnt), 1);

        // Pixel map corners.
        apply_stimulus(10'd144, 10'd31);
        check_output("pix_tl", {int'(video_on), int'(px), int'(py)} == {1, 0, 0} ? 1 : 0, 1);
        apply_stimulus(10'd783, 10'd510);
        check_output("pix_br_px", int'(px), 639);
        check_output("pix_br_py", int'(py), 479);
        apply_stimulus(10'd784, 10'd510);
        check_output("pix_hfp", int'(video_on) + int'(px) + int'(py), 0);

        // In-order sequencing with 10-cycle acks.
        for (int f = 0; f < 3; f++) begin
            delay[0] = 10;
            apply_stimulus(10'd0, 10'(VFP));
            check_output("seq_first_go", int'(upd_go), 1);
            repeat (49) rand_cycle();
            apply_stimulus(10'd0, 10'(VBP));
            repeat (4) rand_cycle();
        end
        check_output("seq_ovr_cnt", int'(ovr_cnt), 0);
        check_output("seq_frame_cnt", int'(frame_cnt), 4);

        // Client 1 never acks.
        run_frame(3, -1, 3, 50, 1);
        check_output("ovr_go", int'(upd_go), 0);
        check_output("ovr_pulse", int'(overrun), 1);
        check_output("ovr_cnt1", int'(ovr_cnt), 1);
        run_frame(3, 3, 3, 30, 1);
        check_output("ovr_recover_cnt", int'(ovr_cnt), 1);

        // Last client done on the deadline cycle: 3*4+5 cycles after start.
        run_frame(4, 4, 4, 16, 1);
        check_output("race_overrun", int'(overrun), 0);
        check_output("race_ovr_cnt", int'(ovr_cnt), 1);
        check_output("race_go", int'(upd_go), 0);

        // Randomized frames with stray acks and occasional missing deadlines.
        stray_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int dd [N];
            for (int i = 0; i < N; i++)
                dd[i] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 20));
            run_frame(dd[0], dd[1], dd[2], int'($urandom_range(5, 70)),
                      $urandom_range(0, 5) != 0);
            repeat ($urandom_range(0, 5)) rand_cycle();
        end

        // Back-to-back illegal blank starts: frame counter wrap, overrun saturation.
        clr = 1'b1;
        model_reset();
        rand_cycle();
        clr = 1'b0;
        for (int i = 0; i < 65535; i++) apply_stimulus(10'd0, 10'(VFP));
        check_output("wrap_pre", int'(frame_cnt), 65535);
        check_output("sat_ovr_cnt", int'(ovr_cnt), 255);
        apply_stimulus(10'd0, 10'(VFP));
        check_output("wrap_zero", int'(frame_cnt), 0);
        check_output("wrap_tick", int'(frame_tick), 1);
        repeat (5) rand_cycle();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
